cam_reg_sequencer: RTL and testbench

- Walks a combinational register-init look-up table and issues one write per entry to the downstream SCCB/I2C write master over a req/ack handshake.
- Generalises the camera config LUT flow:
  - parametrised address, data and index widths
  - in-table delay entries
  - per-entry retry on bus error
  - terminator detection
  - done/error status
- Sits between the LUT module and the SCCB master in the camera init path.

---
 rtl/cam_reg_sequencer_pkg.sv | 37 +++
 rtl/cam_reg_sequencer_delay_timer.sv | 68 ++++++
 rtl/cam_reg_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_cam_reg_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_reg_sequencer_pkg.sv
// ============================================================================
//  Module      : cam_reg_sequencer_pkg
//  Description : Shared state encoding, table marker defaults and LUT entry
//                field helpers for the camera register-init sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_reg_sequencer_pkg;

    localparam logic [15:0] DEF_END_ADDR   = 16'hFFFF;
    localparam logic [15:0] DEF_DELAY_ADDR = 16'hFFFE;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WRITE = 3'd2,
        ST_DELAY = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAIL  = 3'd6
    } seq_state_e;

    // Entries are {addr, data}; callers truncate the 64-bit result to their width.
    function automatic logic [63:0] entry_addr(input logic [63:0] entry,
                                               input int unsigned data_w);
        return entry >> data_w;
    endfunction

    function automatic logic [63:0] entry_data(input logic [63:0] entry,
                                               input int unsigned data_w);
        return entry & ((64'd1 << data_w) - 64'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cam_reg_sequencer_delay_timer.sv
// ============================================================================
//  Module      : cam_delay_timer
//  Description : Prescaled down-counter; pulses expired after units*TICK_DIV
//                cycles following load (first cycle when units is zero).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_delay_timer #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned UNITS_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [UNITS_W-1:0] units,
    output logic               expired
);

    localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [UNITS_W-1:0] units_q, units_d;
    logic               active_q, active_d;
    logic               expired_w;

    always_comb begin
        expired_w = active_q && ((units_q == '0) ||
                                 ((units_q == UNITS_W'(1)) && (pre_q == PRE_LAST)));
        pre_d     = pre_q;
        units_d   = units_q;
        active_d  = active_q;
        if (load) begin
            pre_d    = '0;
            units_d  = units;
            active_d = 1'b1;
        end else if (expired_w) begin
            pre_d    = '0;
            units_d  = '0;
            active_d = 1'b0;
        end else if (active_q) begin
            if (pre_q == PRE_LAST) begin
                pre_d   = '0;
                units_d = units_q - 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            units_q  <= '0;
            active_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            units_q  <= units_d;
            active_q <= active_d;
        end
    end

    assign expired = expired_w;

endmodule

`default_nettype wire

// File: rtl/cam_reg_sequencer.sv
// ============================================================================
//  Module      : cam_reg_sequencer
//  Description : Walks a register-init LUT and issues one SCCB write per entry,
//                with delay entries, per-entry retry and done/error status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_reg_sequencer
    import cam_reg_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       INDEX_W    = 10,
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(DEF_END_ADDR),
    parameter logic [ADDR_W-1:0] DELAY_ADDR = ADDR_W'(DEF_DELAY_ADDR),
    parameter int unsigned       TICK_DIV   = 50000,
    parameter int unsigned       MAX_RETRY  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [INDEX_W-1:0]       lut_index,
    input  logic [ADDR_W+DATA_W-1:0] lut_data,
    output logic                     wr_req,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_ack,
    input  logic                     wr_err,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [INDEX_W-1:0]       err_index
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    seq_state_e          state_q, state_d;
    logic [INDEX_W-1:0]  lut_index_q, lut_index_d;
    logic [ADDR_W-1:0]   entry_addr_q, entry_addr_d;
    logic [DATA_W-1:0]   entry_data_q, entry_data_d;
    logic                wr_req_q, wr_req_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [INDEX_W-1:0]  err_index_q, err_index_d;

    logic [ADDR_W-1:0]   fetch_addr_w;
    logic [DATA_W-1:0]   fetch_data_w;
    logic [RETRY_W-1:0]  retry_inc_w;
    logic                timer_load_w;
    logic                timer_expired_w;

    assign fetch_addr_w = ADDR_W'(entry_addr(64'(lut_data), DATA_W));
    assign fetch_data_w = DATA_W'(entry_data(64'(lut_data), DATA_W));
    assign retry_inc_w  = retry_q + 1'b1;

    cam_delay_timer #(
        .TICK_DIV (TICK_DIV),
        .UNITS_W  (DATA_W)
    ) u_delay_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load_w),
        .units   (fetch_data_w),
        .expired (timer_expired_w)
    );

    always_comb begin
        state_d      = state_q;
        lut_index_d  = lut_index_q;
        entry_addr_d = entry_addr_q;
        entry_data_d = entry_data_q;
        wr_req_d     = wr_req_q;
        retry_d      = retry_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        err_index_d  = err_index_q;
        timer_load_w = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lut_index_d = '0;
                    retry_d     = '0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                entry_addr_d = fetch_addr_w;
                entry_data_d = fetch_data_w;
                if (fetch_addr_w == END_ADDR) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (fetch_addr_w == DELAY_ADDR) begin
                    timer_load_w = 1'b1;
                    state_d      = ST_DELAY;
                end else begin
                    wr_req_d = 1'b1;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // wr_req low while in WRITE is the idle gap before a retry.
                if (!wr_req_q) begin
                    wr_req_d = 1'b1;
                end else if (wr_err) begin
                    wr_req_d = 1'b0;
                    if (retry_inc_w == RETRY_W'(MAX_RETRY)) begin
                        retry_d     = '0;
                        error_d     = 1'b1;
                        err_index_d = lut_index_q;
                        busy_d      = 1'b0;
                        state_d     = ST_FAIL;
                    end else begin
                        retry_d = retry_inc_w;
                    end
                end else if (wr_ack) begin
                    wr_req_d = 1'b0;
                    retry_d  = '0;
                    state_d  = ST_NEXT;
                end
            end
            ST_DELAY: begin
                if (timer_expired_w) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (lut_index_q == '1) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    lut_index_d = lut_index_q + 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_DONE, ST_FAIL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lut_index_q  <= '0;
            entry_addr_q <= '0;
            entry_data_q <= '0;
            wr_req_q     <= 1'b0;
            retry_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_index_q  <= '0;
        end else begin
            state_q      <= state_d;
            lut_index_q  <= lut_index_d;
            entry_addr_q <= entry_addr_d;
            entry_data_q <= entry_data_d;
            wr_req_q     <= wr_req_d;
            retry_q      <= retry_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_index_q  <= err_index_d;
        end
    end

    assign lut_index = lut_index_q;
    assign wr_req    = wr_req_q;
    assign wr_addr   = entry_addr_q;
    assign wr_data   = entry_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_index = err_index_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_reg_sequencer.sv
// ============================================================================
//  Module      : tb_cam_reg_sequencer
//  Description : Scoreboard bench for cam_reg_sequencer with a small LUT and
//                a scripted SCCB responder (ack/err after three cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cam_reg_sequencer;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int INDEX_W   = 3;
    localparam int TICK_DIV  = 10;
    localparam int MAX_RETRY = 3;
    localparam int ACK_LAT   = 3;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          gap;
        bit          first;
    } wr_t;

    typedef struct {
        logic       dn;
        logic       er;
        logic [2:0] ei;
        logic [2:0] ix;
    } st_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        start  = 1'b0;
    logic        wr_ack = 1'b0;
    logic        wr_err = 1'b0;
    logic [2:0]  lut_index;
    logic [23:0] lut_data;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy, done, error;
    logic [2:0]  err_index;

    logic [23:0] lut_mem [8];
    wr_t         exp_q [$];
    st_t         st_q  [$];
    int          rsp_q [$];

    int n_vec     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int rq_cyc    = 0;
    int last_rise = 0;
    logic prev_req  = 1'b0;
    logic prev_busy = 1'b0;

    assign lut_data = lut_mem[lut_index];

    cam_reg_sequencer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .INDEX_W    (INDEX_W),
        .END_ADDR   (16'hFFFF),
        .DELAY_ADDR (16'hFFFE),
        .TICK_DIV   (TICK_DIV),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .lut_index (lut_index),
        .lut_data  (lut_data),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .wr_err    (wr_err),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_index (err_index)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [7:0] d, input int gap, input bit first);
        wr_t w;
        w.a = a; w.d = d; w.gap = gap; w.first = first;
        exp_q.push_back(w);
    endtask

    task automatic exp_st(input logic dn, input logic er, input logic [2:0] ei, input logic [2:0] ix);
        st_t s;
        s.dn = dn; s.er = er; s.ei = ei; s.ix = ix;
        st_q.push_back(s);
    endtask

    task automatic clr_table();
        for (int i = 0; i < 8; i++) lut_mem[i] = 24'hFFFF00;
    endtask

    task automatic do_start();
        @(negedge clk);
        start_cyc = cyc;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
        chk("error_cleared", 32'(error), 32'd0);
        chk("index_zero", 32'(lut_index), 32'd0);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: busy=%0b after %0d cycles, required 0", name, busy, n);
        end
        repeat (3) @(negedge clk);
        chk({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_status_left"}, 32'(st_q.size()), 32'd0);
        rsp_q.delete();
    endtask

    // Downstream SCCB master: responds ACK_LAT cycles after wr_req rises.
    initial begin : responder
        int k;
        forever begin
            @(posedge clk);
            #1;
            wr_ack = 1'b0;
            wr_err = 1'b0;
            if (wr_req === 1'b1) begin
                rq_cyc++;
                if (rq_cyc == ACK_LAT) begin
                    k      = (rsp_q.size() > 0) ? rsp_q.pop_front() : 0;
                    wr_ack = (k != 1);
                    wr_err = (k != 0);
                    rq_cyc = 0;
                end
            end else begin
                rq_cyc = 0;
            end
        end
    end

    initial begin : monitor
        wr_t w;
        st_t s;
        forever begin
            @(negedge clk);
            if (wr_req === 1'b1 && prev_req !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required none", wr_addr, wr_data);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(w.a));
                    chk("wr_data", 32'(wr_data), 32'(w.d));
                    chk("wr_gap", 32'(cyc - (w.first ? start_cyc : last_rise)), 32'(w.gap));
                end
                last_rise = cyc;
            end
            if (busy === 1'b0 && prev_busy === 1'b1 && rst_n) begin
                if (st_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_end: got done=%0b error=%0b, required none", done, error);
                end else begin
                    s = st_q.pop_front();
                    chk("st_done", 32'(done), 32'(s.dn));
                    chk("st_error", 32'(error), 32'(s.er));
                    chk("st_index", 32'(lut_index), 32'(s.ix));
                    if (s.er) chk("st_err_index", 32'(err_index), 32'(s.ei));
                end
            end
            prev_req  = wr_req;
            prev_busy = busy;
        end
    end

    initial begin : driver
        int n;
        clr_table();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_lut_index", 32'(lut_index), 32'd0);
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_index", 32'(err_index), 32'd0);
        rst_n = 1'b1;

        // Two writes then terminator
        clr_table();
        lut_mem[0] = {16'h0014, 8'h40};
        lut_mem[1] = {16'h00FF, 8'h01};
        exp_wr(16'h0014, 8'h40, 2, 1);
        exp_wr(16'h00FF, 8'h01, 5, 0);
        exp_st(1'b1, 1'b0, 3'd0, 3'd2);
        do_start();
        wait_idle("basic");

        // Delay entries of 2 units and 0 units
        clr_table();
        lut_mem[0] = {16'h0011, 8'hAA};
        lut_mem[1] = {16'hFFFE, 8'h02};
        lut_mem[2] = {16'h0022, 8'hBB};
        lut_mem[3] = {16'hFFFE, 8'h00};
        lut_mem[4] = {16'h0033, 8'hCC};
        exp_wr(16'h0011, 8'hAA, 2, 1);
        exp_wr(16'h0022, 8'hBB, 27, 0);
        exp_wr(16'h0033, 8'hCC, 8, 0);
        exp_st(1'b1, 1'b0, 3'd0, 3'd5);
        do_start();
        wait_idle("delay");

        // Two errors then ack on entry 1
        clr_table();
        lut_mem[0] = {16'h0010, 8'h01};
        lut_mem[1] = {16'h0020, 8'h02};
        rsp_q = '{0, 1, 1, 0};
        exp_wr(16'h0010, 8'h01, 2, 1);
        exp_wr(16'h0020, 8'h02, 5, 0);
        exp_wr(16'h0020, 8'h02, 4, 0);
        exp_wr(16'h0020, 8'h02, 4, 0);
        exp_st(1'b1, 1'b0, 3'd0, 3'd2);
        do_start();
        wait_idle("retry");

        // Retry exhaustion on entry 2, then restart
        clr_table();
        lut_mem[0] = {16'h0030, 8'h03};
        lut_mem[1] = {16'h0040, 8'h04};
        lut_mem[2] = {16'h0050, 8'h05};
        lut_mem[3] = {16'h0060, 8'h06};
        rsp_q = '{0, 0, 1, 1, 1};
        exp_wr(16'h0030, 8'h03, 2, 1);
        exp_wr(16'h0040, 8'h04, 5, 0);
        exp_wr(16'h0050, 8'h05, 5, 0);
        exp_wr(16'h0050, 8'h05, 4, 0);
        exp_wr(16'h0050, 8'h05, 4, 0);
        exp_st(1'b0, 1'b1, 3'd2, 3'd2);
        do_start();
        wait_idle("fail");
        chk("error_sticky", 32'(error), 32'd1);
        chk("done_after_fail", 32'(done), 32'd0);
        chk("err_index_hold", 32'(err_index), 32'd2);
        exp_wr(16'h0030, 8'h03, 2, 1);
        exp_wr(16'h0040, 8'h04, 5, 0);
        exp_wr(16'h0050, 8'h05, 5, 0);
        exp_wr(16'h0060, 8'h06, 5, 0);
        exp_st(1'b1, 1'b0, 3'd0, 3'd4);
        do_start();
        wait_idle("restart");

        // start while busy must be ignored
        clr_table();
        lut_mem[0] = {16'h0014, 8'h40};
        lut_mem[1] = {16'h00FF, 8'h01};
        exp_wr(16'h0014, 8'h40, 2, 1);
        exp_wr(16'h00FF, 8'h01, 5, 0);
        exp_st(1'b1, 1'b0, 3'd0, 3'd2);
        do_start();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("start_busy");

        // Asynchronous reset during WRITE
        exp_wr(16'h0014, 8'h40, 2, 1);
        do_start();
        n = 0;
        while (wr_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_req_seen", 32'(wr_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_req", 32'(wr_req), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_error", 32'(error), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle_req", 32'(wr_req), 32'd0);
            chk("post_rst_idle_busy", 32'(busy), 32'd0);
        end
        chk("post_rst_writes_left", 32'(exp_q.size()), 32'd0);
        rsp_q.delete();

        // No terminator: all 8 entries written, done at index 7
        for (int i = 0; i < 8; i++) begin
            lut_mem[i] = {16'(16'h0100 + i), 8'(i * 17)};
            exp_wr(16'(16'h0100 + i), 8'(i * 17), (i == 0) ? 2 : 5, i == 0);
        end
        exp_st(1'b1, 1'b0, 3'd0, 3'd7);
        do_start();
        wait_idle("wrap");

        // ack together with err counts as an error
        clr_table();
        lut_mem[0] = {16'h0070, 8'h07};
        rsp_q = '{2, 2, 2};
        exp_wr(16'h0070, 8'h07, 2, 1);
        exp_wr(16'h0070, 8'h07, 4, 0);
        exp_wr(16'h0070, 8'h07, 4, 0);
        exp_st(1'b0, 1'b1, 3'd0, 3'd0);
        do_start();
        wait_idle("ack_err");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
